// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from an MSB- or LSB-first bit stream.
// Word appears on dout on the same edge as its last bit; one-word holding slot, a word that
// completes while the slot is still occupied is dropped and raises the sticky overrun flag.
module shift_deser #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             frame_start,
    input  logic             dout_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_base;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_base;
    logic             dir_lat;
    logic             dir_eff;
    logic             word_done;
    logic             slot_free;

    // frame_start discards the partial word first, so an accompanying bit starts a fresh word
    always_comb begin
        sreg_base = frame_start ? '0 : sreg;
        cnt_base  = frame_start ? '0 : bit_cnt;
        dir_eff   = (frame_start || (bit_cnt == '0)) ? dir : dir_lat;
        shifted   = dir_eff ? {sin, sreg_base[WIDTH-1:1]}
                            : {sreg_base[WIDTH-2:0], sin};
        word_done = sin_valid && (cnt_base == LAST_BIT);
        slot_free = !dout_valid || dout_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            dir_lat <= 1'b0;
        end else begin
            if (frame_start || (sin_valid && (bit_cnt == '0))) begin
                dir_lat <= dir;
            end
            if (sin_valid) begin
                sreg    <= shifted;
                bit_cnt <= word_done ? '0 : cnt_base + CNT_W'(1);
            end else if (frame_start) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end
        end
    end

    // Holding slot: a completing word may replace the held one only if it leaves this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done && slot_free) begin
                dout       <= shifted;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (word_done && !slot_free) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_shift_deser.sv
// Randomised and directed bench for shift_deser with a bit-list reference model and a word scoreboard.
module tb_shift_deser;
    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sin = 1'b0;
    logic          sin_valid = 1'b0;
    logic          dir = 1'b0;
    logic          frame_start = 1'b0;
    logic          dout_ready = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int           m_bits[$];
    logic         m_dir;
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_over;
    logic [W-1:0] sb[$];

    shift_deser #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .dir(dir),
        .frame_start(frame_start), .dout_ready(dout_ready), .overrun_clr(overrun_clr),
        .dout(dout), .dout_valid(dout_valid), .overrun(overrun), .busy(busy),
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input logic lsb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (lsb_first) w[i] = m_bits[i][0];
            else           w[W-1-i] = m_bits[i][0];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        sb.delete();
        m_dir   = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from the inputs now driven
    task automatic model_edge();
        logic set_over;
        logic loaded;
        set_over = 1'b0;
        loaded   = 1'b0;
        if (frame_start) begin
            m_bits.delete();
            m_dir = dir;
        end
        if (sin_valid) begin
            if (m_bits.size() == 0) m_dir = dir;
            m_bits.push_back(int'(sin));
            if (m_bits.size() == W) begin
                if (!m_valid || dout_ready) begin
                    m_dout = word_of(m_dir);
                    sb.push_back(m_dout);
                    loaded = 1'b1;
                end else begin
                    set_over = 1'b1;
                end
                m_bits.delete();
            end
        end
        if (loaded)                    m_valid = 1'b1;
        else if (m_valid && dout_ready) m_valid = 1'b0;
        if (set_over)         m_over = 1'b1;
        else if (overrun_clr) m_over = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".dout"},       32'(dout),       32'(m_dout));
        check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        check({tag, ".overrun"},    32'(overrun),    32'(m_over));
        check({tag, ".bit_cnt"},    32'(bit_cnt),    32'(m_bits.size()));
        check({tag, ".busy"},       32'(busy),       32'(m_bits.size() != 0));
    endtask

    // Called 2 time units after a rising edge; returns at the same phase of the next cycle
    task automatic cyc(input logic sv, input logic s, input logic d, input logic fs,
                       input logic rdy, input logic clr, input string tag);
        sin_valid   = sv;
        sin         = s;
        dir         = d;
        frame_start = fs;
        dout_ready  = rdy;
        overrun_clr = clr;
        model_edge();
        @(posedge clk);
        #1;
        check_state(tag);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] val, input logic d, input logic rdy_last,
                             input logic clr_last, input string tag);
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, d ? val[i] : val[W-1-i], d, 1'b0,
                (i == W-1) ? rdy_last : 1'b0, (i == W-1) ? clr_last : 1'b0, tag);
        end
    endtask

    task automatic idle(input logic rdy, input logic clr, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, clr, tag);
    endtask

    // Scoreboard monitor: every transfer must deliver the oldest word the model loaded
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake: got %0h with no word expected at %0t", dout, $time);
            end else begin
                check("handshake", 32'(dout), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check_state("reset");
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: MSB-first 1,0,1,1
        send_word(4'b1011, 1'b0, 1'b0, 1'b0, "t1");
        check("t1.word", 32'(dout), 32'h0000_000b);
        idle(1'b1, 1'b0, "t1.drain");

        // 2: LSB-first 1,0,1,1
        send_word(4'b1101, 1'b1, 1'b0, 1'b0, "t2");
        check("t2.word", 32'(dout), 32'h0000_000d);
        idle(1'b1, 1'b0, "t2.take");
        check("t2.kept", 32'(dout), 32'h0000_000d);

        // 3: overrun, clear, and set winning over a simultaneous clear
        send_word(4'hA, 1'b0, 1'b0, 1'b0, "t3a");
        send_word(4'h5, 1'b0, 1'b0, 1'b0, "t3b");
        check("t3.held", 32'(dout), 32'h0000_000a);
        check("t3.over", 32'(overrun), 32'h1);
        idle(1'b0, 1'b1, "t3.clr");
        check("t3.cleared", 32'(overrun), 32'h0);
        send_word(4'h9, 1'b0, 1'b0, 1'b1, "t3c");
        check("t3.setwins", 32'(overrun), 32'h1);
        idle(1'b1, 1'b1, "t3.drain");

        // 4: back-to-back words with ready only on the completing edge
        send_word(4'h3, 1'b0, 1'b0, 1'b0, "t4a");
        send_word(4'hC, 1'b0, 1'b1, 1'b0, "t4b");
        check("t4.word", 32'(dout), 32'h0000_000c);
        check("t4.over", 32'(overrun), 32'h0);
        idle(1'b1, 1'b0, "t4.drain");

        // 5: resync with an accompanying bit, dir toggled mid-word
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5.pre0");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5.pre1");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t5.fs");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5.b1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5.b2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5.b3");
        check("t5.word", 32'(dout), 32'h0000_0009);

        // 6: asynchronous reset mid-word while a word is held
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6.b0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6.b1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6.b2");
        sin_valid = 1'b0;
        dout_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check_state("t6.async");
        @(posedge clk);
        #2;
        rst = 1'b1;
        send_word(4'h6, 1'b0, 1'b0, 1'b0, "t6.after");
        check("t6.word", 32'(dout), 32'h0000_0006);
        idle(1'b1, 1'b0, "t6.drain");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, "rand");
        end
        for (int n = 0; n < 3; n++) idle(1'b1, 1'b0, "final");
        check("scoreboard_left", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
